// File: rtl/conv_sched_pkg.sv
// Shared types for the conv2d job scheduler: FSM encoding and the job and
// completion record layouts.
package conv_sched_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CYC_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_CPL     = 3'd3,
    ST_RECOVER = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CYC_W-1:0] cycles;
    logic             timeout;
  } cpl_rec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [TAG_W-1:0]  tag;
  } job_rec_t;

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous FIFO holding queued job records; full/empty derive from a
// registered occupancy count.
module conv_job_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/conv2d_job_scheduler.sv
// Queues conv2d jobs and runs a single engine through them one at a time,
// relocating engine addresses and reporting tag, cycle count and timeout.
module conv2d_job_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned JOB_DEPTH      = 4,
  parameter int unsigned CYC_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_in_base,
  input  logic [ADDR_WIDTH-1:0] job_out_base,
  input  logic [TAG_WIDTH-1:0]  job_tag,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic                  eng_soft_rst,
  input  logic [ADDR_WIDTH-1:0] eng_input_addr,
  input  logic                  eng_input_en,
  input  logic [ADDR_WIDTH-1:0] eng_output_addr,
  input  logic                  eng_output_en,
  input  logic                  eng_output_we,
  output logic [ADDR_WIDTH-1:0] mem_input_addr,
  output logic                  mem_input_en,
  output logic [ADDR_WIDTH-1:0] mem_output_addr,
  output logic                  mem_output_en,
  output logic                  mem_output_we,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [TAG_WIDTH-1:0]  cpl_tag,
  output logic [CYC_WIDTH-1:0]  cpl_cycles,
  output logic                  cpl_timeout,
  output logic                  busy
);

  localparam int unsigned JW = 2*ADDR_WIDTH + TAG_WIDTH;
  localparam logic [CYC_WIDTH-1:0] TMO = CYC_WIDTH'(TIMEOUT_CYCLES);

  sched_state_t state_q, state_d;

  logic [JW-1:0]              fifo_rdata;
  logic                       fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(JOB_DEPTH):0] fifo_count;

  logic [ADDR_WIDTH-1:0] in_base_q, out_base_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [CYC_WIDTH-1:0]  cnt_q, cnt_inc, cyc_q;
  logic                  tmo_q, tmo_hit, run_en;

  conv_job_fifo #(
    .WIDTH (JW),
    .DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (job_valid),
    .wdata ({job_in_base, job_out_base, job_tag}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // rst_n term keeps job_ready low while reset is held.
  assign job_ready = rst_n && !fifo_full;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = (cnt_inc >= TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    eng_start    = 1'b0;
    eng_soft_rst = 1'b0;
    cpl_valid    = 1'b0;
    run_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        eng_start = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (eng_done)     state_d = ST_CPL;
        else if (tmo_hit) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        eng_soft_rst = 1'b1;
        state_d      = ST_CPL;
      end
      ST_CPL: begin
        cpl_valid = 1'b1;
        if (cpl_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_base_q  <= '0;
      out_base_q <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      if (fifo_pop) {in_base_q, out_base_q, tag_q} <= fifo_rdata;
      if (state_q == ST_LAUNCH) cnt_q <= '0;
      else if (run_en)          cnt_q <= cnt_inc;
      // Done has priority over timeout when both land in the same cycle.
      if (run_en) begin
        if (eng_done) begin
          cyc_q <= cnt_inc;
          tmo_q <= 1'b0;
        end else if (tmo_hit) begin
          cyc_q <= TMO;
          tmo_q <= 1'b1;
        end
      end
    end
  end

  assign cpl_tag     = tag_q;
  assign cpl_cycles  = cyc_q;
  assign cpl_timeout = tmo_q;

  assign mem_input_addr  = in_base_q + eng_input_addr;
  assign mem_output_addr = out_base_q + eng_output_addr;
  assign mem_input_en    = run_en && eng_input_en;
  assign mem_output_en   = run_en && eng_output_en;
  assign mem_output_we   = run_en && eng_output_we;

endmodule
